// File: rtl/prince_cms_pkg.sv
// rtl/prince_cms_pkg.sv - shared sizes, index helpers and vector types for the CMS compression stage
// Purpose: default share/term geometry of the PRINCE CMS S-box layer and the
//          flat-vector index conventions used by the compression stage.
// Ports:   none (package).
package prince_cms_pkg;

  localparam int NUM_BITS   = 4;
  localparam int NUM_TERMS  = 9;
  localparam int NUM_SHARES = 3;

  typedef logic [NUM_BITS*NUM_TERMS-1:0]  term_vec_t;
  typedef logic [NUM_BITS*NUM_SHARES-1:0] share_vec_t;

  // Term t of S-box output bit b in the flat term vector.
  function automatic int term_idx(input int b, input int t, input int nterms = NUM_TERMS);
    return b * nterms + t;
  endfunction

  // Share j of S-box output bit b in the flat share vector.
  function automatic int share_idx(input int b, input int j, input int nshares = NUM_SHARES);
    return b * nshares + j;
  endfunction

endpackage

// File: rtl/cms_compress_xor.sv
// rtl/cms_compress_xor.sv - XOR reduction of TPS registered terms into one share bit
// Purpose: purely combinational compression of one group of component terms.
// Ports:
//   terms_i  in  TPS  registered component-function terms of one share group
//   share_o  out 1    XOR of all terms in the group
module cms_compress_xor #(
  parameter int TPS = 3
) (
  input  logic [TPS-1:0] terms_i,
  output logic           share_o
);

  assign share_o = ^terms_i;

endmodule

// File: rtl/prince_sbox_cms_compress.sv
// rtl/prince_sbox_cms_compress.sv - two-stage registered share compression after the CMS S-box products
// Purpose: S1 registers the raw component terms (glitch isolation), S2 registers
//          their XOR compression into output shares. Valid/ready handshake on both ends.
// Ports:
//   clk          in  1                    clock, rising edge
//   rst          in  1                    synchronous active-high reset
//   in_valid_i   in  1                    terms_i carries valid component outputs
//   in_ready_o   out 1                    stage accepts terms_i this cycle
//   terms_i      in  NUM_BITS*NUM_TERMS   index b*NUM_TERMS+t = term t of bit b
//   out_valid_o  out 1                    shares_o valid
//   out_ready_i  in  1                    consumer accepts shares_o
//   shares_o     out NUM_BITS*NUM_SHARES  index b*NUM_SHARES+j = share j of bit b
module prince_sbox_cms_compress
  import prince_cms_pkg::*;
#(
  parameter int NUM_BITS   = prince_cms_pkg::NUM_BITS,
  parameter int NUM_TERMS  = prince_cms_pkg::NUM_TERMS,
  parameter int NUM_SHARES = prince_cms_pkg::NUM_SHARES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [NUM_BITS*NUM_TERMS-1:0]    terms_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [NUM_BITS*NUM_SHARES-1:0]   shares_o
);

  localparam int TPS = NUM_TERMS / NUM_SHARES;

  if ((NUM_TERMS % NUM_SHARES) != 0) begin : g_bad_cfg
    $error("NUM_TERMS must be a multiple of NUM_SHARES");
  end

  logic [NUM_BITS*NUM_TERMS-1:0]  r_t_q;
  logic [NUM_BITS*NUM_SHARES-1:0] r_sh_q;
  logic                           r_s1_valid;
  logic                           r_s2_valid;

  logic                           w_s1_adv;
  logic                           w_s2_adv;
  logic [NUM_BITS*NUM_SHARES-1:0] w_sh_d;

  // Ready depends only on valid flags and out_ready_i, never on share data.
  assign w_s2_adv   = !r_s2_valid || out_ready_i;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready_o = w_s1_adv;

  // Compression reads S1 registers only; each term feeds exactly one share.
  for (genvar b = 0; b < NUM_BITS; b++) begin : g_bit
    for (genvar j = 0; j < NUM_SHARES; j++) begin : g_share
      cms_compress_xor #(
        .TPS (TPS)
      ) u_xor (
        .terms_i (r_t_q[term_idx(b, j*TPS, NUM_TERMS) +: TPS]),
        .share_o (w_sh_d[share_idx(b, j, NUM_SHARES)])
      );
    end
  end

  // Data registers load only on a real transfer; on idle cycles they hold
  // rather than clear so share wires see no extra transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t_q      <= '0;
      r_sh_q     <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid_i;
      end
      if (in_valid_i && w_s1_adv) begin
        r_t_q <= terms_i;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (r_s1_valid && w_s2_adv) begin
        r_sh_q <= w_sh_d;
      end
    end
  end

  assign shares_o    = r_sh_q;
  assign out_valid_o = r_s2_valid;

endmodule

// File: tb/tb_prince_sbox_cms_compress.sv
// tb/tb_prince_sbox_cms_compress.sv - self-checking bench for the CMS compression stage
module tb_prince_sbox_cms_compress;
  import prince_cms_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  term_vec_t   terms_i;
  logic        out_valid_o;
  logic        out_ready_i;
  share_vec_t  shares_o;

  int checks;
  int failures;

  prince_sbox_cms_compress dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .terms_i     (terms_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .shares_o    (shares_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    term_vec_t  terms;
    share_vec_t exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic term_vec_t rnd_terms();
    return {4'($urandom), $urandom};
  endfunction

  term_vec_t  bp_terms[4];
  share_vec_t bp_exp[4];

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{36'h000000001, 12'h001};
    vecs[1] = '{36'h000000008, 12'h002};
    vecs[2] = '{36'h000000200, 12'h008};
    vecs[3] = '{36'h0000001FF, 12'h007};
    vecs[4] = '{36'h000000007, 12'h001};
    vecs[5] = '{36'hFFFFFFFFF, 12'hFFF};
    vecs[6] = '{36'h800000000, 12'h800};
    vecs[7] = '{36'h000000049, 12'h007};

    rst         = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    terms_i     = '0;
    step();
    step();
    chk("reset_out_valid", out_valid_o, 0);
    chk("reset_shares", shares_o, 0);
    chk("reset_in_ready", in_ready_o, 1);
    rst = 1'b0;

    // Table: one isolated item per vector, two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1;
      terms_i    = vecs[i].terms;
      step();
      in_valid_i = 1'b0;
      terms_i    = rnd_terms();
      chk($sformatf("vec%0d_lat1_valid", i), out_valid_o, 0);
      if (i == 0) chk("vec0_shares_before", shares_o, 0);
      step();
      chk($sformatf("vec%0d_valid", i), out_valid_o, 1);
      chk($sformatf("vec%0d_shares", i), shares_o, vecs[i].exp);
      step();
      chk($sformatf("vec%0d_drained", i), out_valid_o, 0);
    end

    // Idle hold: random don't-care terms must not disturb either stage.
    for (int c = 0; c < 5; c++) begin
      in_valid_i = 1'b0;
      terms_i    = rnd_terms();
      step();
      chk("idle_t_q", dut.r_t_q, vecs[7].terms);
      chk("idle_shares", shares_o, vecs[7].exp);
      chk("idle_out_valid", out_valid_o, 0);
    end

    // Backpressure: four back-to-back items, consumer stalls from cycle 1 to 5.
    bp_terms[0] = 36'h000000001; bp_exp[0] = 12'h001;
    bp_terms[1] = 36'h000000008; bp_exp[1] = 12'h002;
    bp_terms[2] = 36'h000000200; bp_exp[2] = 12'h008;
    bp_terms[3] = 36'h0000001FF; bp_exp[3] = 12'h007;
    begin
      int sent;
      int got;
      bit held_v;
      share_vec_t held;
      sent   = 0;
      got    = 0;
      held_v = 0;
      held   = '0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        in_valid_i  = (sent < 4);
        terms_i     = (sent < 4) ? bp_terms[sent] : rnd_terms();
        out_ready_i = (cyc == 0) || (cyc >= 6);
        #1;
        if (cyc == 3) begin
          chk("bp_in_ready_low", in_ready_o, 0);
          chk("bp_accepted_two", sent, 2);
        end
        if (cyc == 6) chk("bp_full_in_ready", in_ready_o, 1);
        if (!out_ready_i && out_valid_o) begin
          if (held_v) chk("bp_stall_stable", shares_o, held);
          held   = shares_o;
          held_v = 1;
        end
        if (cyc >= 6) chk("bp_no_bubble", out_valid_o, 1);
        if (out_valid_o && out_ready_i) begin
          chk($sformatf("bp_item%0d", got), shares_o, bp_exp[got]);
          got++;
        end
        if (in_valid_i && in_ready_o) sent++;
        step();
      end
      in_valid_i = 1'b0;
      chk("bp_sent", sent, 4);
      chk("bp_received", got, 4);
      chk("bp_no_dup", out_valid_o, 0);
    end

    // Mid-operation reset with both stages holding items.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    terms_i     = 36'hFFFFFFFFF;
    step();
    terms_i     = 36'h000000007;
    step();
    in_valid_i  = 1'b0;
    chk("mr_full_valid", out_valid_o, 1);
    chk("mr_full_in_ready", in_ready_o, 0);
    rst = 1'b1;
    step();
    chk("mr_out_valid", out_valid_o, 0);
    chk("mr_shares", shares_o, 0);
    chk("mr_in_ready", in_ready_o, 1);
    rst         = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      terms_i = rnd_terms();
      step();
      chk("mr_no_stale", out_valid_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
